// File: rtl/prism_pkg.sv
// Shared types and constants for the PRISM debug-port configuration loader.
package prism_pkg;

    localparam int PRISM_DBG_AW      = 6;
    localparam int PRISM_WORD_STRIDE = 4;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        COLLECT,
        WRITE,
        RELEASE
    } ld_state_t;

endpackage

// File: rtl/prism_dbg_arb.sv
// Purpose: CPU-priority two-way mux onto the PRISM 32-bit debug write port.
// Latency: purely combinational, zero cycles.
// Backpressure: none here; the loader stalls itself whenever cpu_wr_i is high.
module prism_dbg_arb
    import prism_pkg::*;
(
    input  logic                    cpu_wr_i,
    input  logic [PRISM_DBG_AW-1:0] cpu_addr_i,
    input  logic [31:0]             cpu_wdata_i,
    input  logic                    ld_wr_i,
    input  logic [PRISM_DBG_AW-1:0] ld_addr_i,
    input  logic [31:0]             ld_wdata_i,
    output logic                    dbg_wr_o,
    output logic [PRISM_DBG_AW-1:0] dbg_addr_o,
    output logic [31:0]             dbg_wdata_o
);

    // Address and data sit at zero whenever the port is not being written.
    always_comb begin
        dbg_wr_o    = 1'b0;
        dbg_addr_o  = '0;
        dbg_wdata_o = '0;
        if (cpu_wr_i) begin
            dbg_wr_o    = 1'b1;
            dbg_addr_o  = cpu_addr_i;
            dbg_wdata_o = cpu_wdata_i;
        end else if (ld_wr_i) begin
            dbg_wr_o    = 1'b1;
            dbg_addr_o  = ld_addr_i;
            dbg_wdata_o = ld_wdata_i;
        end
    end

endmodule

// File: rtl/prism_loader.sv
// Purpose: assemble a byte stream into LE 32-bit words and write them to PRISM tables, holding the FSM in reset.
// Latency: 2 + 5*WORDS cycles from start to done, +1 per stalled byte or CPU write during COLLECT/WRITE.
// Backpressure: byte_ready drops outside COLLECT and whenever a CPU write owns the debug port.
module prism_loader
    import prism_pkg::*;
#(
    parameter int unsigned                 WORDS     = 8,
    parameter logic [PRISM_DBG_AW-1:0]     BASE_ADDR = 6'h04
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    byte_valid,
    input  logic [7:0]              byte_data,
    output logic                    byte_ready,
    input  logic                    cpu_wr,
    input  logic [PRISM_DBG_AW-1:0] cpu_addr,
    input  logic [31:0]             cpu_wdata,
    output logic                    dbg_wr,
    output logic [PRISM_DBG_AW-1:0] dbg_addr,
    output logic [31:0]             dbg_wdata,
    output logic                    fsm_reset,
    output logic                    fsm_enable,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam logic [3:0]              WORDS_L  = 4'(WORDS);
    localparam logic [PRISM_DBG_AW-1:0] STRIDE_L = PRISM_DBG_AW'(PRISM_WORD_STRIDE);

    ld_state_t               state_q, state_d;
    logic [1:0]              k_q, k_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [PRISM_DBG_AW-1:0] addr_q, addr_d;
    logic [31:0]             word_q, word_d;
    logic                    fsm_enable_q, fsm_enable_d;
    logic                    err_q, err_d;
    logic                    ld_wr;

    assign busy       = (state_q != IDLE);
    assign fsm_reset  = (state_q == HALT) || (state_q == COLLECT) || (state_q == WRITE);
    assign fsm_enable = fsm_enable_q;
    assign done       = (state_q == RELEASE);
    assign err        = err_q;

    // Gating with rst keeps a synchronous reset from leaking a half-finished write.
    assign byte_ready = !rst && (state_q == COLLECT) && !cpu_wr;
    assign ld_wr      = !rst && (state_q == WRITE) && !cpu_wr;

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        word_d       = word_q;
        fsm_enable_d = fsm_enable_q;
        err_d        = 1'b0;
        if (busy && abort) begin
            state_d      = IDLE;
            fsm_enable_d = 1'b0;
            err_d        = 1'b1;
        end else begin
            if (busy && start) begin
                err_d = 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        state_d      = HALT;
                        k_d          = '0;
                        cnt_d        = '0;
                        addr_d       = BASE_ADDR;
                        fsm_enable_d = 1'b0;
                    end
                end
                HALT: state_d = COLLECT;
                COLLECT: begin
                    if (byte_valid && byte_ready) begin
                        word_d[{k_q, 3'b000} +: 8] = byte_data;
                        k_d = k_q + 2'd1;
                        if (k_q == 2'd3) begin
                            state_d = WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (ld_wr) begin
                        addr_d = addr_q + STRIDE_L;
                        cnt_d  = cnt_q + 4'd1;
                        if (cnt_q + 4'd1 == WORDS_L) begin
                            state_d      = RELEASE;
                            fsm_enable_d = 1'b1;
                        end else begin
                            state_d = COLLECT;
                        end
                    end
                end
                RELEASE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            k_q          <= '0;
            cnt_q        <= '0;
            addr_q       <= '0;
            word_q       <= '0;
            fsm_enable_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            word_q       <= word_d;
            fsm_enable_q <= fsm_enable_d;
            err_q        <= err_d;
        end
    end

    prism_dbg_arb u_arb (
        .cpu_wr_i    (cpu_wr),
        .cpu_addr_i  (cpu_addr),
        .cpu_wdata_i (cpu_wdata),
        .ld_wr_i     (ld_wr),
        .ld_addr_i   (addr_q),
        .ld_wdata_i  (word_q),
        .dbg_wr_o    (dbg_wr),
        .dbg_addr_o  (dbg_addr),
        .dbg_wdata_o (dbg_wdata)
    );

endmodule

// File: tb/tb_prism_loader.sv
// Self-checking bench for prism_loader: directed scenarios plus randomized loads against a step-level model.
module tb_prism_loader;

    localparam int         WORDS = 2;
    localparam logic [5:0] BASE  = 6'h04;

    logic        clk = 1'b0;
    logic        rst, start, abort, byte_valid, byte_ready, cpu_wr;
    logic [7:0]  byte_data;
    logic [5:0]  cpu_addr, dbg_addr;
    logic [31:0] cpu_wdata, dbg_wdata;
    logic        dbg_wr, fsm_reset, fsm_enable, busy, done, err;

    int checks   = 0;
    int failures = 0;

    prism_loader #(.WORDS(WORDS), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .dbg_wr(dbg_wr), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .fsm_reset(fsm_reset), .fsm_enable(fsm_enable), .busy(busy),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        cpu;
        logic        dbg_wr;
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic        brdy;
        logic        frst;
        logic        fen;
        logic        busy;
        logic        done;
        logic        err;
    } obs_t;

    typedef struct {
        int          t;
        logic [5:0]  addr;
        logic [31:0] data;
    } wr_t;

    obs_t        obs[$];
    wr_t         ld_log[$];
    wr_t         cpu_log[$];
    logic [7:0]  src_q[$];
    bit          stall[int];
    logic [5:0]  c_addr[int];
    logic [31:0] c_data[int];
    int          abort_t, xstart_t, rst_t, done_t, err_n;

    task automatic clear_cfg();
        src_q.delete(); stall.delete(); c_addr.delete(); c_data.delete();
        abort_t = -1; xstart_t = -1; rst_t = -1;
    endtask

    task automatic idle_inputs();
        start = 0; abort = 0; rst = 0; cpu_wr = 0; byte_valid = 0;
        cpu_addr = '0; cpu_wdata = '0; byte_data = '0;
    endtask

    // Cycle t=0 carries the start pulse; every later cycle is logged in obs[t].
    task automatic run_load(input int budget);
        bit acc;
        acc = 0;
        obs.delete(); ld_log.delete(); cpu_log.delete();
        done_t = -1; err_n = 0;
        for (int t = 0; t < budget; t++) begin
            @(posedge clk); #1;
            if (acc) void'(src_q.pop_front());
            start      = (t == 0) || (t == xstart_t);
            abort      = (t == abort_t);
            rst        = (t == rst_t);
            cpu_wr     = c_addr.exists(t);
            cpu_addr   = cpu_wr ? c_addr[t] : 6'($urandom);
            cpu_wdata  = cpu_wr ? c_data[t] : $urandom;
            byte_valid = (src_q.size() > 0) && !stall.exists(t);
            byte_data  = byte_valid ? src_q[0] : 8'($urandom);
            @(negedge clk);
            acc = byte_valid && byte_ready;
            obs.push_back('{cpu_wr, dbg_wr, dbg_addr, dbg_wdata, byte_ready,
                            fsm_reset, fsm_enable, busy, done, err});
            if (dbg_wr && cpu_wr) cpu_log.push_back('{t, dbg_addr, dbg_wdata});
            else if (dbg_wr)      ld_log.push_back('{t, dbg_addr, dbg_wdata});
            if (done && done_t < 0) done_t = t;
            if (err) err_n++;
            if (done_t >= 0 && t >= done_t + 2) break;
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic test_reset();
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0) begin
                repeat (3) @(posedge clk);
            end else begin
                @(posedge clk); #1; rst = 0;
                @(posedge clk);
            end
            @(negedge clk);
            checks++;
            if ({dbg_wr, byte_ready, fsm_reset, fsm_enable, busy, done, err} !== 7'b0) begin
                failures++;
                $display("FAIL reset_flags pass=%0d got=%b exp=0000000", pass,
                         {dbg_wr, byte_ready, fsm_reset, fsm_enable, busy, done, err});
            end
            checks++;
            if (dbg_addr !== 6'h0) begin
                failures++; $display("FAIL reset_dbg_addr got=%h exp=00", dbg_addr);
            end
            checks++;
            if (dbg_wdata !== 32'h0) begin
                failures++; $display("FAIL reset_dbg_wdata got=%h exp=00000000", dbg_wdata);
            end
        end
    endtask

    task automatic test_basic();
        logic [31:0] exp_d[2];
        int          exp_t[2];
        exp_d = '{32'h04030201, 32'h08070605};
        exp_t = '{6, 11};
        clear_cfg();
        for (int i = 0; i < 8; i++) src_q.push_back(8'(i + 1));
        run_load(40);
        checks++;
        if (ld_log.size() != 2) begin
            failures++; $display("FAIL basic_wr_count got=%0d exp=2", ld_log.size());
        end
        for (int w = 0; w < 2; w++) begin
            checks++;
            if (w >= ld_log.size() || ld_log[w].addr !== BASE + 6'(4 * w) ||
                ld_log[w].data !== exp_d[w] || ld_log[w].t != exp_t[w]) begin
                failures++;
                $display("FAIL basic_word%0d got=%h@%h t=%0d exp=%h@%h t=%0d", w,
                         (w < ld_log.size()) ? ld_log[w].data : 32'hx,
                         (w < ld_log.size()) ? ld_log[w].addr : 6'hx,
                         (w < ld_log.size()) ? ld_log[w].t : -1,
                         exp_d[w], BASE + 6'(4 * w), exp_t[w]);
            end
        end
        checks++;
        if (done_t != 12) begin
            failures++; $display("FAIL basic_latency got=%0d exp=12", done_t);
        end
        checks++;
        if ({obs[1].frst, obs[1].fen, obs[1].busy} !== 3'b101) begin
            failures++;
            $display("FAIL basic_halt_outputs got=%b exp=101", {obs[1].frst, obs[1].fen, obs[1].busy});
        end
        checks++;
        if (done_t < 0 || {obs[done_t + 1].fen, obs[done_t + 1].busy, obs[done_t].frst} !== 3'b100) begin
            failures++; $display("FAIL basic_release got done_t=%0d exp enable=1 busy=0 reset=0", done_t);
        end
        checks++;
        if (err_n != 0) begin
            failures++; $display("FAIL basic_err got=%0d exp=0", err_n);
        end
    endtask

    task automatic test_cpu_collision();
        clear_cfg();
        for (int i = 0; i < 8; i++) src_q.push_back(8'(i + 1));
        c_addr[6] = 6'h20; c_data[6] = 32'hDEADBEEF;
        run_load(40);
        checks++;
        if (cpu_log.size() != 1 || cpu_log[0].t != 6 || cpu_log[0].addr !== 6'h20 ||
            cpu_log[0].data !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL collision_cpu_write got n=%0d exp one write 20<=deadbeef at t=6", cpu_log.size());
        end
        checks++;
        if (ld_log.size() != 2 || ld_log[0].t != 7 || ld_log[0].addr !== 6'h04 ||
            ld_log[0].data !== 32'h04030201) begin
            failures++;
            $display("FAIL collision_deferred got n=%0d t=%0d exp 04<=04030201 at t=7",
                     ld_log.size(), (ld_log.size() > 0) ? ld_log[0].t : -1);
        end
        checks++;
        if (ld_log.size() != 2 || ld_log[1].t != 12 || ld_log[1].addr !== 6'h08 ||
            ld_log[1].data !== 32'h08070605) begin
            failures++; $display("FAIL collision_second_word got n=%0d exp 08<=08070605 at t=12", ld_log.size());
        end
        checks++;
        if (done_t != 13) begin
            failures++; $display("FAIL collision_latency got=%0d exp=13", done_t);
        end
    endtask

    task automatic test_stall();
        clear_cfg();
        for (int i = 0; i < 8; i++) src_q.push_back(8'(8'h10 * i + 8'h0A));
        for (int t = 3; t <= 5; t++) stall[t] = 1;
        run_load(40);
        checks++;
        if (ld_log.size() != 2) begin
            failures++; $display("FAIL stall_wr_count got=%0d exp=2", ld_log.size());
        end
        checks++;
        if (ld_log.size() != 2 || ld_log[0].data !== 32'h3A2A1A0A || ld_log[1].data !== 32'h7A6A5A4A) begin
            failures++;
            $display("FAIL stall_words got=%h,%h exp=3a2a1a0a,7a6a5a4a",
                     (ld_log.size() > 0) ? ld_log[0].data : 32'hx, (ld_log.size() > 1) ? ld_log[1].data : 32'hx);
        end
        checks++;
        if (done_t != 15) begin
            failures++; $display("FAIL stall_latency got=%0d exp=15", done_t);
        end
    endtask

    task automatic test_start_busy();
        clear_cfg();
        for (int i = 0; i < 8; i++) src_q.push_back(8'(8'hA0 + i));
        xstart_t = 3;
        run_load(40);
        checks++;
        if (obs[4].err !== 1'b1 || err_n != 1) begin
            failures++; $display("FAIL start_busy_err got err[4]=%b count=%0d exp 1,1", obs[4].err, err_n);
        end
        checks++;
        if (done_t != 12) begin
            failures++; $display("FAIL start_busy_latency got=%0d exp=12", done_t);
        end
        checks++;
        if (ld_log.size() != 2 || ld_log[0].data !== 32'hA3A2A1A0 || ld_log[1].data !== 32'hA7A6A5A4) begin
            failures++; $display("FAIL start_busy_words got n=%0d exp a3a2a1a0,a7a6a5a4", ld_log.size());
        end
    endtask

    task automatic test_abort();
        @(posedge clk); #1; abort = 1;
        @(posedge clk); #1; abort = 0;
        @(negedge clk);
        checks++;
        if ({err, busy, fsm_enable} !== 3'b001) begin
            failures++; $display("FAIL abort_idle got err,busy,en=%b exp=001", {err, busy, fsm_enable});
        end
        clear_cfg();
        for (int i = 0; i < 8; i++) src_q.push_back(8'(8'h30 + i));
        abort_t = 8;
        run_load(14);
        checks++;
        if (ld_log.size() != 1) begin
            failures++; $display("FAIL abort_wr_count got=%0d exp=1", ld_log.size());
        end
        checks++;
        if (obs[9].err !== 1'b1 || obs[10].err !== 1'b0) begin
            failures++; $display("FAIL abort_err_pulse got=%b%b exp=10", obs[9].err, obs[10].err);
        end
        checks++;
        if ({obs[9].frst, obs[9].fen, obs[9].busy} !== 3'b000) begin
            failures++;
            $display("FAIL abort_outputs got rst,en,busy=%b exp=000", {obs[9].frst, obs[9].fen, obs[9].busy});
        end
        checks++;
        if (done_t != -1) begin
            failures++; $display("FAIL abort_no_done got done at %0d exp none", done_t);
        end
    endtask

    task automatic test_rst_mid_write();
        clear_cfg();
        for (int i = 0; i < 8; i++) src_q.push_back(8'(8'h50 + i));
        rst_t = 6;
        run_load(10);
        checks++;
        if (obs[6].dbg_wr !== 1'b0 || ld_log.size() != 0) begin
            failures++; $display("FAIL rst_write got dbg_wr=%b writes=%0d exp 0,0", obs[6].dbg_wr, ld_log.size());
        end
        checks++;
        if ({obs[7].dbg_wr, obs[7].brdy, obs[7].frst, obs[7].fen, obs[7].busy, obs[7].done, obs[7].err} !== 7'b0 ||
            obs[7].addr !== 6'h0 || obs[7].wdata !== 32'h0) begin
            failures++;
            $display("FAIL rst_outputs got flags=%b addr=%h data=%h exp all zero",
                     {obs[7].dbg_wr, obs[7].brdy, obs[7].frst, obs[7].fen, obs[7].busy, obs[7].done, obs[7].err},
                     obs[7].addr, obs[7].wdata);
        end
    endtask

    // Model: the load is a fixed list of steps; a byte step needs a valid byte and a
    // free port, a write step needs a free port, HALT/RELEASE always advance.
    task automatic test_random();
        for (int it = 0; it < 20; it++) begin
            logic [7:0] sent[$];
            int         need[$];
            int         exp_wt[$];
            int         tm, bad, j;
            logic [31:0] ew;
            clear_cfg();
            for (int i = 0; i < 4 * WORDS; i++) sent.push_back(8'($urandom));
            foreach (sent[i]) src_q.push_back(sent[i]);
            for (int t = 2; t < 60; t++) if ($urandom_range(3) == 0) stall[t] = 1;
            for (int t = 0; t < 14; t++) begin
                if ($urandom_range(4) == 0) begin
                    c_addr[t] = 6'($urandom);
                    c_data[t] = $urandom;
                end
            end
            need.push_back(0);
            for (int w = 0; w < WORDS; w++) begin
                for (int b = 0; b < 4; b++) need.push_back(1);
                need.push_back(2);
            end
            tm = 1;
            foreach (need[n]) begin
                while (!(need[n] == 0 ||
                         (need[n] == 1 && !stall.exists(tm) && !c_addr.exists(tm)) ||
                         (need[n] == 2 && !c_addr.exists(tm)))) tm++;
                if (need[n] == 2) exp_wt.push_back(tm);
                tm++;
            end
            run_load(80);
            checks++;
            if (done_t != tm) begin
                failures++; $display("FAIL rand%0d_latency got=%0d exp=%0d", it, done_t, tm);
            end
            for (int w = 0; w < WORDS; w++) begin
                ew = {sent[4*w+3], sent[4*w+2], sent[4*w+1], sent[4*w]};
                checks++;
                if (w >= ld_log.size() || ld_log[w].data !== ew ||
                    ld_log[w].addr !== BASE + 6'(4 * w) || ld_log[w].t != exp_wt[w]) begin
                    failures++;
                    $display("FAIL rand%0d_word%0d got=%h t=%0d exp=%h t=%0d", it, w,
                             (w < ld_log.size()) ? ld_log[w].data : 32'hx,
                             (w < ld_log.size()) ? ld_log[w].t : -1, ew, exp_wt[w]);
                end
            end
            checks++;
            bad = (cpu_log.size() != c_addr.num()) ? 1 : 0;
            j = 0;
            foreach (c_addr[t]) begin
                if (j >= cpu_log.size() || cpu_log[j].t != t || cpu_log[j].addr !== c_addr[t] ||
                    cpu_log[j].data !== c_data[t]) bad++;
                j++;
            end
            if (bad != 0) begin
                failures++;
                $display("FAIL rand%0d_cpu_passthru got=%0d writes exp=%0d (bad=%0d)",
                         it, cpu_log.size(), c_addr.num(), bad);
            end
            checks++;
            bad = 0;
            foreach (obs[t]) if (obs[t].cpu && obs[t].brdy) bad++;
            if (bad != 0 || err_n != 0) begin
                failures++; $display("FAIL rand%0d_gating got ready_during_cpu=%0d err=%0d exp 0,0", it, bad, err_n);
            end
        end
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        rst = 1;
        test_reset();
        test_basic();
        test_cpu_collision();
        test_stall();
        test_start_busy();
        test_abort();
        test_rst_mid_write();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
